// File: rtl/fusion_ddr_pkg.sv
// Shared DDR/MCB definitions: command opcodes, default field widths and the
// arbiter state type.
package fusion_ddr_pkg;

  localparam logic [2:0] MCB_CMD_WR = 3'b000;
  localparam logic [2:0] MCB_CMD_RD = 3'b001;
  localparam int         DDR_ADDR_W = 30;
  localparam int         DDR_BL_W   = 6;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mcb_cmd_arbiter_if.sv
// Client request/grant signals and the MCB command port of the arbiter.
// The slave side is the arbiter; the master side drives requests and MCB status.
interface mcb_cmd_arbiter_if import fusion_ddr_pkg::*; #(
  parameter int ADDR_W  = DDR_ADDR_W,
  parameter int BL_W    = DDR_BL_W,
  parameter int OUTST_W = 3
);
  logic              calib_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [BL_W-1:0]   wr_bl;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [BL_W-1:0]   rd_bl;
  logic              rd_gnt;
  logic              rd_burst_done;
  logic              cmd_full;
  logic              cmd_en;
  logic [2:0]        cmd_instr;
  logic [ADDR_W-1:0] cmd_byte_addr;
  logic [BL_W-1:0]   cmd_bl;
  logic [OUTST_W-1:0] rd_outstanding;
  logic              busy;
  logic              err_underflow;

  modport slave (
    input  calib_done, wr_req, wr_addr, wr_bl, rd_req, rd_addr, rd_bl,
           rd_burst_done, cmd_full,
    output wr_gnt, rd_gnt, cmd_en, cmd_instr, cmd_byte_addr, cmd_bl,
           rd_outstanding, busy, err_underflow
  );

  modport master (
    output calib_done, wr_req, wr_addr, wr_bl, rd_req, rd_addr, rd_bl,
           rd_burst_done, cmd_full,
    input  wr_gnt, rd_gnt, cmd_en, cmd_instr, cmd_byte_addr, cmd_bl,
           rd_outstanding, busy, err_underflow
  );

endinterface

// File: rtl/rd_credit_ctr.sv
// Up/down count of read bursts in flight, with a sticky flag for a drain
// reported while nothing was outstanding.
module rd_credit_ctr #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         err
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX);

  // A simultaneous issue and drain cancel out; the MAX guard is only a backstop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      err   <= 1'b0;
    end else if (inc && !dec) begin
      if (count != MAX_CNT) count <= count + 1'b1;
    end else if (dec && !inc) begin
      if (count == '0) err   <= 1'b1;
      else             count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mcb_cmd_arbiter.sv
// Round-robin sharing of one MCB command port between a write and a read
// client, one command per grant, with read bursts limited by a credit count.
module mcb_cmd_arbiter import fusion_ddr_pkg::*; #(
  parameter int ADDR_W       = DDR_ADDR_W,
  parameter int BL_W         = DDR_BL_W,
  parameter int MAX_RD_OUTST = 4,
  parameter int OUTST_W      = 3
) (
  input logic              clk,
  input logic              reset,
  mcb_cmd_arbiter_if.slave bus
);

  localparam logic [OUTST_W-1:0] MAX_OUT = OUTST_W'(MAX_RD_OUTST);

  arb_state_t         state;
  logic               prefer_rd;
  logic               win_rd;
  logic               cmd_en_q;
  logic               wr_gnt_q;
  logic               rd_gnt_q;
  logic [2:0]         instr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BL_W-1:0]    bl_q;
  logic [OUTST_W-1:0] rd_count;
  logic               underflow;
  logic               wr_elig;
  logic               rd_elig;
  logic               pick_rd;

  assign wr_elig = bus.wr_req & bus.calib_done;
  assign rd_elig = bus.rd_req & bus.calib_done & (rd_count < MAX_OUT);
  assign pick_rd = rd_elig & (~wr_elig | prefer_rd);

  // prefer_rd flips to the client not served last; cleared means write wins ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      prefer_rd <= 1'b0;
      win_rd    <= 1'b0;
      cmd_en_q  <= 1'b0;
      wr_gnt_q  <= 1'b0;
      rd_gnt_q  <= 1'b0;
      instr_q   <= MCB_CMD_WR;
      addr_q    <= '0;
      bl_q      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (wr_elig || rd_elig) begin
            win_rd  <= pick_rd;
            instr_q <= pick_rd ? MCB_CMD_RD : MCB_CMD_WR;
            addr_q  <= pick_rd ? bus.rd_addr : bus.wr_addr;
            bl_q    <= pick_rd ? bus.rd_bl : bus.wr_bl;
            state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (!bus.cmd_full) begin
            cmd_en_q  <= 1'b1;
            wr_gnt_q  <= ~win_rd;
            rd_gnt_q  <= win_rd;
            prefer_rd <= ~win_rd;
            state     <= ARB_GAP;
          end
        end
        ARB_GAP: begin
          cmd_en_q <= 1'b0;
          wr_gnt_q <= 1'b0;
          rd_gnt_q <= 1'b0;
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  rd_credit_ctr #(
    .MAX (MAX_RD_OUTST),
    .W   (OUTST_W)
  ) u_rd_credit (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_gnt_q),
    .dec   (bus.rd_burst_done),
    .count (rd_count),
    .err   (underflow)
  );

  assign bus.cmd_en         = cmd_en_q;
  assign bus.wr_gnt         = wr_gnt_q;
  assign bus.rd_gnt         = rd_gnt_q;
  assign bus.cmd_instr      = instr_q;
  assign bus.cmd_byte_addr  = addr_q;
  assign bus.cmd_bl         = bl_q;
  assign bus.rd_outstanding = rd_count;
  assign bus.busy           = (state != ARB_IDLE);
  assign bus.err_underflow  = underflow;

endmodule

// File: tb/tb_mcb_cmd_arbiter.sv
// Bench for mcb_cmd_arbiter: per-cycle vector table, directed corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mcb_cmd_arbiter;
  import fusion_ddr_pkg::*;

  localparam int MAX_OUT = 4;
  localparam logic [29:0] WR_A = 30'h80;
  localparam logic [5:0]  WR_B = 6'd31;
  localparam logic [29:0] RD_A = 30'h1000;
  localparam logic [5:0]  RD_B = 6'd15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  mcb_cmd_arbiter_if #(.ADDR_W(30), .BL_W(6), .OUTST_W(3)) bus();

  mcb_cmd_arbiter #(
    .ADDR_W(30), .BL_W(6), .MAX_RD_OUTST(MAX_OUT), .OUTST_W(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr_req, rd_req, rd_done, cmd_full;
    logic exp_busy, exp_en, exp_wgnt, exp_rgnt;
    logic [2:0] exp_out;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input int w, r, d, f, b, e, wg, rg, o);
    vec_t v;
    v.wr_req = (w != 0); v.rd_req = (r != 0); v.rd_done = (d != 0); v.cmd_full = (f != 0);
    v.exp_busy = (b != 0); v.exp_en = (e != 0); v.exp_wgnt = (wg != 0); v.exp_rgnt = (rg != 0);
    v.exp_out = 3'(o);
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaves the caller in the drive slot just after a rising edge.
  task automatic do_reset(input logic calib);
    reset = 1'b1;
    bus.calib_done = calib;
    bus.wr_req = 1'b0; bus.wr_addr = WR_A; bus.wr_bl = WR_B;
    bus.rd_req = 1'b0; bus.rd_addr = RD_A; bus.rd_bl = RD_B;
    bus.rd_burst_done = 1'b0; bus.cmd_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.wr_req = v.wr_req; bus.rd_req = v.rd_req;
    bus.rd_burst_done = v.rd_done; bus.cmd_full = v.cmd_full;
  endtask

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    bit seq[8];
    bit got_rd, got_en;
    int en_seen;

    // Table: single write, then R/W/R round robin, then cmd_full back-pressure.
    vecs[0]  = mk(1,0,0,0, 0,0,0,0, 0);
    vecs[1]  = mk(1,0,0,0, 1,0,0,0, 0);
    vecs[2]  = mk(1,0,0,0, 1,1,1,0, 0);
    vecs[3]  = mk(0,0,0,0, 0,0,0,0, 0);
    vecs[4]  = mk(0,0,0,0, 0,0,0,0, 0);
    vecs[5]  = mk(1,1,0,0, 0,0,0,0, 0);
    vecs[6]  = mk(1,1,0,0, 1,0,0,0, 0);
    vecs[7]  = mk(1,1,0,0, 1,1,0,1, 0);
    vecs[8]  = mk(1,0,1,0, 0,0,0,0, 1);
    vecs[9]  = mk(1,1,0,0, 1,0,0,0, 0);
    vecs[10] = mk(1,1,0,0, 1,1,1,0, 0);
    vecs[11] = mk(0,1,0,0, 0,0,0,0, 0);
    vecs[12] = mk(0,1,0,0, 1,0,0,0, 0);
    vecs[13] = mk(0,1,0,0, 1,1,0,1, 0);
    vecs[14] = mk(0,0,0,1, 0,0,0,0, 1);
    vecs[15] = mk(1,0,0,1, 0,0,0,0, 1);
    vecs[16] = mk(1,0,0,1, 1,0,0,0, 1);
    vecs[17] = mk(1,0,0,0, 1,0,0,0, 1);
    vecs[18] = mk(1,0,0,0, 1,1,1,0, 1);
    vecs[19] = mk(0,0,0,0, 0,0,0,0, 1);

    do_reset(1'b1);
    @(negedge clk);
    check_output("reset_en",    32'(bus.cmd_en), 0);
    check_output("reset_instr", 32'(bus.cmd_instr), 0);
    check_output("reset_addr",  32'(bus.cmd_byte_addr), 0);
    check_output("reset_bl",    32'(bus.cmd_bl), 0);
    check_output("reset_err",   32'(bus.err_underflow), 0);
    next_slot();

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("vec%0d_busy", i),  32'(bus.busy),   32'(vecs[i].exp_busy));
      check_output($sformatf("vec%0d_en", i),    32'(bus.cmd_en), 32'(vecs[i].exp_en));
      check_output($sformatf("vec%0d_wgnt", i),  32'(bus.wr_gnt), 32'(vecs[i].exp_wgnt));
      check_output($sformatf("vec%0d_rgnt", i),  32'(bus.rd_gnt), 32'(vecs[i].exp_rgnt));
      check_output($sformatf("vec%0d_outst", i), 32'(bus.rd_outstanding), 32'(vecs[i].exp_out));
      if (vecs[i].exp_en) begin
        check_output($sformatf("vec%0d_instr", i), 32'(bus.cmd_instr),
                     32'(vecs[i].exp_rgnt ? MCB_CMD_RD : MCB_CMD_WR));
        check_output($sformatf("vec%0d_addr", i), 32'(bus.cmd_byte_addr),
                     32'(vecs[i].exp_rgnt ? RD_A : WR_A));
        check_output($sformatf("vec%0d_bl", i), 32'(bus.cmd_bl),
                     32'(vecs[i].exp_rgnt ? RD_B : WR_B));
      end
      next_slot();
    end

    // Both clients held from reset: W first, then strict alternation.
    do_reset(1'b1);
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      got_rd = bus.rd_gnt; got_en = bus.cmd_en;
      next_slot();
      bus.rd_burst_done = got_en & got_rd;
      if (got_en) begin seq[n] = got_rd; n++; end
    end
    bus.rd_burst_done = 1'b0;
    check_output("alt_count", 32'(n), 4);
    for (int i = 0; i < n; i++)
      check_output($sformatf("alt_grant%0d_is_rd", i), 32'(seq[i]), 32'(i % 2));

    // Credit limit: four reads in flight block the fifth until one drains.
    do_reset(1'b1);
    bus.rd_req = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.rd_gnt) n++;
      next_slot();
    end
    check_output("cap_grants", 32'(n), 4);
    check_output("cap_outst", 32'(bus.rd_outstanding), 4);
    bus.rd_burst_done = 1'b1;
    next_slot();
    bus.rd_burst_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.rd_gnt) n++;
      next_slot();
    end
    check_output("cap_grants_after_drain", 32'(n), 5);
    check_output("cap_outst_after_drain", 32'(bus.rd_outstanding), 4);
    bus.rd_req = 1'b0;

    // cmd_full stall; req and calib_done drop while the command waits.
    do_reset(1'b1);
    bus.wr_req = 1'b1; bus.cmd_full = 1'b1;
    next_slot();
    bus.wr_req = 1'b0; bus.calib_done = 1'b0;
    en_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.cmd_en) en_seen++;
      check_output($sformatf("full%0d_addr", c), 32'(bus.cmd_byte_addr), 32'(WR_A));
      check_output($sformatf("full%0d_busy", c), 32'(bus.busy), 1);
      next_slot();
    end
    check_output("full_no_en", 32'(en_seen), 0);
    bus.cmd_full = 1'b0;
    @(negedge clk);
    check_output("full_release_en_early", 32'(bus.cmd_en), 0);
    next_slot();
    @(negedge clk);
    check_output("full_release_en", 32'(bus.cmd_en), 1);
    check_output("full_release_wgnt", 32'(bus.wr_gnt), 1);
    check_output("full_release_bl", 32'(bus.cmd_bl), 32'(WR_B));
    next_slot();

    // No grant until calibration completes, then W two cycles later.
    do_reset(1'b0);
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    en_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.cmd_en || bus.busy) en_seen++;
      next_slot();
    end
    check_output("calib_low_idle", 32'(en_seen), 0);
    bus.calib_done = 1'b1;
    @(negedge clk);
    check_output("calib_rise_busy0", 32'(bus.busy), 0);
    next_slot();
    @(negedge clk);
    check_output("calib_rise_en1", 32'(bus.cmd_en), 0);
    next_slot();
    @(negedge clk);
    check_output("calib_rise_en2", 32'(bus.cmd_en), 1);
    check_output("calib_rise_wgnt", 32'(bus.wr_gnt), 1);
    next_slot();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;

    // Underflow is sticky; then an async reset wipes a stalled command.
    do_reset(1'b1);
    bus.rd_burst_done = 1'b1;
    next_slot();
    bus.rd_burst_done = 1'b0;
    @(negedge clk);
    check_output("uflow_err", 32'(bus.err_underflow), 1);
    check_output("uflow_outst", 32'(bus.rd_outstanding), 0);
    repeat (3) next_slot();
    check_output("uflow_sticky", 32'(bus.err_underflow), 1);
    bus.rd_req = 1'b1;
    n = 0;
    for (int c = 0; c < 10 && n == 0; c++) begin
      @(negedge clk);
      if (bus.rd_gnt) n = 1;
      next_slot();
    end
    check_output("pre_reset_rd_gnt", 32'(n), 1);
    bus.rd_req = 1'b0; bus.wr_req = 1'b1; bus.cmd_full = 1'b1;
    next_slot();
    check_output("pre_reset_busy", 32'(bus.busy), 1);
    check_output("pre_reset_outst", 32'(bus.rd_outstanding), 1);
    reset = 1'b1;
    #1;
    check_output("mid_reset_busy",  32'(bus.busy), 0);
    check_output("mid_reset_outst", 32'(bus.rd_outstanding), 0);
    check_output("mid_reset_err",   32'(bus.err_underflow), 0);
    check_output("mid_reset_addr",  32'(bus.cmd_byte_addr), 0);
    check_output("mid_reset_en",    32'(bus.cmd_en), 0);
    bus.wr_req = 1'b0; bus.cmd_full = 1'b0;
    next_slot();
    reset = 1'b0;
    en_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.cmd_en) en_seen++;
      next_slot();
    end
    check_output("reset_dropped_cmd", 32'(en_seen), 0);

    random_phase();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Random clients against a transaction-level model: credit count, held
  // request fields, command spacing, round-robin fairness and liveness.
  task automatic random_phase();
    int model_cnt = 0;
    bit last_rd = 1'b1;
    bit wr_all = 1'b1, rd_all = 1'b1;
    int last_en = -10;
    int wr_wait = 0, rd_wait = 0, max_wait = 0, grants = 0;
    bit wr_pend = 1'b0, rd_pend = 1'b0, done_now, rd_win;
    logic [29:0] wa = '0, ra = '0;
    logic [5:0]  wb = '0, rb = '0;

    do_reset(1'b1);
    for (int c = 0; c < 3000; c++) begin
      if (!wr_pend && $urandom_range(2) == 0) begin
        wr_pend = 1'b1; wa = 30'($urandom); wb = 6'($urandom);
      end
      if (!rd_pend && $urandom_range(2) == 0) begin
        rd_pend = 1'b1; ra = 30'($urandom); rb = 6'($urandom);
      end
      done_now = (model_cnt > 0) && ($urandom_range(3) == 0);
      bus.wr_req = wr_pend; bus.wr_addr = wa; bus.wr_bl = wb;
      bus.rd_req = rd_pend; bus.rd_addr = ra; bus.rd_bl = rb;
      bus.rd_burst_done = done_now;
      bus.cmd_full   = ($urandom_range(3) == 0);
      bus.calib_done = ($urandom_range(19) != 0);

      @(negedge clk);
      check_output("rnd_outst", 32'(bus.rd_outstanding), 32'(model_cnt));
      if (bus.cmd_en) begin
        rd_win = bus.rd_gnt;
        grants++;
        check_output("rnd_gnt_onehot", 32'(bus.wr_gnt) + 32'(bus.rd_gnt), 1);
        check_output("rnd_instr", 32'(bus.cmd_instr), 32'(rd_win ? MCB_CMD_RD : MCB_CMD_WR));
        check_output("rnd_was_pending", 32'(rd_win ? rd_pend : wr_pend), 1);
        check_output("rnd_addr", 32'(bus.cmd_byte_addr), 32'(rd_win ? ra : wa));
        check_output("rnd_bl", 32'(bus.cmd_bl), 32'(rd_win ? rb : wb));
        check_output("rnd_spacing_ok", 32'(c - last_en >= 3), 1);
        if (rd_win) check_output("rnd_credit_ok", 32'(model_cnt < MAX_OUT), 1);
        if (rd_win == last_rd)
          check_output("rnd_rr_other_starved", 32'(rd_win ? wr_all : rd_all), 0);
        last_rd = rd_win; last_en = c;
        wr_all = 1'b1; rd_all = 1'b1;
        if (rd_win) rd_pend = 1'b0; else wr_pend = 1'b0;
      end else begin
        check_output("rnd_no_gnt", 32'(bus.wr_gnt | bus.rd_gnt), 0);
        wr_all = wr_all & bus.wr_req & bus.calib_done;
        rd_all = rd_all & bus.rd_req & bus.calib_done & (model_cnt < MAX_OUT);
      end
      model_cnt = model_cnt + int'(bus.rd_gnt) - int'(done_now);
      wr_wait = wr_pend ? wr_wait + 1 : 0;
      rd_wait = rd_pend ? rd_wait + 1 : 0;
      if (wr_wait > max_wait) max_wait = wr_wait;
      if (rd_wait > max_wait) max_wait = rd_wait;
      next_slot();
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.rd_burst_done = 1'b0;
    check_output("rnd_liveness", 32'(max_wait < 150), 1);
    check_output("rnd_progress", 32'(grants > 100), 1);
  endtask

endmodule
